// File: rtl/usb_utmi_pkg.sv
// Shared UTMI types and full-speed bus timing constants (48 MHz, 4x oversampled domain).
package usb_utmi_pkg;

  typedef enum logic [1:0] {
    UTMI_LS_SE0 = 2'b00,
    UTMI_LS_DJ  = 2'b01,
    UTMI_LS_DK  = 2'b10,
    UTMI_LS_SE1 = 2'b11
  } utmi_line_state_t;

  typedef enum logic [1:0] {
    ACTIVE    = 2'd0,
    BUS_RESET = 2'd1,
    SUSPEND   = 2'd2,
    RESUME    = 2'd3
  } usb_bus_state_t;

  // 2.5 us of SE0, 3 ms of idle J, 2 FS bit times of gap
  localparam int USB_FS_RESET_CYCLES   = 120;
  localparam int USB_FS_SUSPEND_CYCLES = 144000;
  localparam int USB_FS_IPG_CYCLES     = 8;

endpackage

// File: rtl/usb_run_cnt.sv
// Saturating run-length counter: counts consecutive enabled cycles up to LIMIT.
module usb_run_cnt #(
  parameter int LIMIT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic hit,
  output logic sat
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr || !en) begin
      cnt <= '0;
    end else if (cnt != W'(LIMIT)) begin
      cnt <= cnt + 1'b1;
    end
  end

  // hit marks the sample that completes the LIMIT-long run
  assign hit = en && (cnt == W'(LIMIT - 1));
  assign sat = (cnt == W'(LIMIT));

endmodule

// File: rtl/usb_utm_bus_ctrl.sv
// Full-speed bus state tracker (reset/suspend/resume) and half-duplex transmitter arbiter.
module usb_utm_bus_ctrl
  import usb_utmi_pkg::*;
#(
  parameter int RESET_CYCLES   = USB_FS_RESET_CYCLES,
  parameter int SUSPEND_CYCLES = USB_FS_SUSPEND_CYCLES,
  parameter int IPG_CYCLES     = USB_FS_IPG_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  utmi_line_state_t line_state,
  input  logic             rx_active,
  input  logic             tx_active,
  input  logic             tx_req,
  output logic             tx_gnt,
  output logic             suspend_m,
  output logic             usb_reset,
  output logic             resume_det,
  output usb_bus_state_t   bus_state
);

  usb_bus_state_t state, state_next;
  logic se0_en, idle_en, gap_en, cnt_clr;
  logic se0_hit, se0_sat, idle_hit, idle_sat, gap_hit, gap_sat;
  logic gnt_next, resume_next;
  logic unused_flags;

  assign se0_en  = (line_state == UTMI_LS_SE0);
  assign idle_en = (line_state == UTMI_LS_DJ) && !rx_active && !tx_active;
  assign gap_en  = !rx_active && !tx_active;
  assign cnt_clr = (state == BUS_RESET) && (state_next == ACTIVE);

  usb_run_cnt #(.LIMIT(RESET_CYCLES)) u_se0_cnt (
    .clk (clk),
    .rst (rst),
    .en  (se0_en),
    .clr (cnt_clr),
    .hit (se0_hit),
    .sat (se0_sat)
  );

  usb_run_cnt #(.LIMIT(SUSPEND_CYCLES)) u_idle_cnt (
    .clk (clk),
    .rst (rst),
    .en  (idle_en),
    .clr (cnt_clr),
    .hit (idle_hit),
    .sat (idle_sat)
  );

  usb_run_cnt #(.LIMIT(IPG_CYCLES)) u_gap_cnt (
    .clk (clk),
    .rst (rst),
    .en  (gap_en),
    .clr (1'b0),
    .hit (gap_hit),
    .sat (gap_sat)
  );

  assign unused_flags = ^{se0_sat, idle_sat, gap_hit};

  always_comb begin
    state_next = state;
    unique case (state)
      ACTIVE: begin
        if (se0_hit)       state_next = BUS_RESET;
        else if (idle_hit) state_next = SUSPEND;
      end
      BUS_RESET: begin
        if (line_state != UTMI_LS_SE0) state_next = ACTIVE;
      end
      SUSPEND: begin
        if (se0_hit)                         state_next = BUS_RESET;
        else if (line_state == UTMI_LS_DK)   state_next = RESUME;
      end
      RESUME: begin
        // K and short SE0 (resume EOP) keep us here
        if (se0_hit)                         state_next = BUS_RESET;
        else if (line_state == UTMI_LS_DJ)   state_next = ACTIVE;
      end
      default: state_next = ACTIVE;
    endcase
  end

  always_comb begin
    gnt_next = 1'b0;
    // grant is dropped on the very edge that leaves ACTIVE
    if (state == ACTIVE && state_next == ACTIVE) begin
      if (tx_gnt) gnt_next = tx_req;
      else        gnt_next = tx_req && !rx_active && gap_sat;
    end
    resume_next = (state_next == RESUME) && (state != RESUME);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ACTIVE;
      tx_gnt     <= 1'b0;
      resume_det <= 1'b0;
    end else begin
      state      <= state_next;
      tx_gnt     <= gnt_next;
      resume_det <= resume_next;
    end
  end

  assign suspend_m = (state != SUSPEND);
  assign usb_reset = (state == BUS_RESET);
  assign bus_state = state;

endmodule

// File: tb/tb_usb_utm_bus_ctrl.sv
// Directed self-checking bench for usb_utm_bus_ctrl (short suspend time for speed).
module tb_usb_utm_bus_ctrl;
  import usb_utmi_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  utmi_line_state_t line_state;
  logic             rx_active, tx_active, tx_req;
  logic             tx_gnt, suspend_m, usb_reset, resume_det;
  usb_bus_state_t   bus_state;

  int checks   = 0;
  int failures = 0;

  usb_utm_bus_ctrl #(
    .RESET_CYCLES   (120),
    .SUSPEND_CYCLES (200),
    .IPG_CYCLES     (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .line_state (line_state),
    .rx_active  (rx_active),
    .tx_active  (tx_active),
    .tx_req     (tx_req),
    .tx_gnt     (tx_gnt),
    .suspend_m  (suspend_m),
    .usb_reset  (usb_reset),
    .resume_det (resume_det),
    .bus_state  (bus_state)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; line_state = UTMI_LS_DK;
    rx_active = 1'b0; tx_active = 1'b0; tx_req = 1'b0;
    tick(3);
    checks++; if (bus_state !== ACTIVE) begin failures++; $display("FAIL rst_state got=%0d exp=%0d", bus_state, ACTIVE); end
    checks++; if ({suspend_m, usb_reset, tx_gnt, resume_det} !== 4'b1000) begin failures++; $display("FAIL rst_outs got=%b exp=1000", {suspend_m, usb_reset, tx_gnt, resume_det}); end
    rst = 1'b0;
    tick(2);
  endtask

  task automatic test_bus_reset;
    line_state = UTMI_LS_SE0;
    tick(119);
    checks++; if (usb_reset !== 1'b0) begin failures++; $display("FAIL br_119 got=%b exp=0", usb_reset); end
    tick();
    checks++; if (usb_reset !== 1'b1) begin failures++; $display("FAIL br_120 got=%b exp=1", usb_reset); end
    checks++; if (bus_state !== BUS_RESET) begin failures++; $display("FAIL br_state got=%0d exp=%0d", bus_state, BUS_RESET); end
    line_state = UTMI_LS_DJ;
    tick();
    checks++; if (usb_reset !== 1'b0 || bus_state !== ACTIVE) begin failures++; $display("FAIL br_exit got=%b/%0d exp=0/%0d", usb_reset, bus_state, ACTIVE); end
    line_state = UTMI_LS_SE0;
    tick(119);
    line_state = UTMI_LS_DK;
    tick();
    checks++; if (usb_reset !== 1'b0 || bus_state !== ACTIVE) begin failures++; $display("FAIL br_short got=%b/%0d exp=0/%0d", usb_reset, bus_state, ACTIVE); end
  endtask

  task automatic test_eop_immunity;
    for (int p = 0; p < 3; p++) begin
      rx_active = 1'b1; line_state = UTMI_LS_DK;
      tick(20);
      rx_active = 1'b0; line_state = UTMI_LS_SE0;
      tick(8);
      line_state = UTMI_LS_DJ;
      tick(2);
      checks++; if (usb_reset !== 1'b0 || bus_state !== ACTIVE) begin failures++; $display("FAIL eop_%0d got=%b/%0d exp=0/%0d", p, usb_reset, bus_state, ACTIVE); end
    end
    line_state = UTMI_LS_DK;
    tick();
  endtask

  task automatic test_suspend_resume;
    line_state = UTMI_LS_DJ;
    tick(199);
    checks++; if (suspend_m !== 1'b1) begin failures++; $display("FAIL susp_199 got=%b exp=1", suspend_m); end
    tick();
    checks++; if (suspend_m !== 1'b0 || bus_state !== SUSPEND) begin failures++; $display("FAIL susp_200 got=%b/%0d exp=0/%0d", suspend_m, bus_state, SUSPEND); end
    tx_req = 1'b1;
    tick(20);
    checks++; if (tx_gnt !== 1'b0) begin failures++; $display("FAIL susp_gnt got=%b exp=0", tx_gnt); end
    line_state = UTMI_LS_DK;
    tick();
    checks++; if (bus_state !== RESUME || suspend_m !== 1'b1 || resume_det !== 1'b1) begin failures++; $display("FAIL res_entry got=%0d/%b/%b exp=%0d/1/1", bus_state, suspend_m, resume_det, RESUME); end
    tick();
    checks++; if (resume_det !== 1'b0) begin failures++; $display("FAIL res_pulse got=%b exp=0", resume_det); end
    tick(78);
    checks++; if (bus_state !== RESUME || resume_det !== 1'b0 || tx_gnt !== 1'b0) begin failures++; $display("FAIL res_hold got=%0d/%b/%b exp=%0d/0/0", bus_state, resume_det, tx_gnt, RESUME); end
    tx_req = 1'b0;
    line_state = UTMI_LS_SE0;
    tick(2);
    checks++; if (bus_state !== RESUME) begin failures++; $display("FAIL res_eop got=%0d exp=%0d", bus_state, RESUME); end
    line_state = UTMI_LS_DJ;
    tick();
    checks++; if (bus_state !== ACTIVE) begin failures++; $display("FAIL res_exit got=%0d exp=%0d", bus_state, ACTIVE); end
    tick(200);
    checks++; if (bus_state !== SUSPEND) begin failures++; $display("FAIL susp2 got=%0d exp=%0d", bus_state, SUSPEND); end
    line_state = UTMI_LS_SE0;
    tick(119);
    checks++; if (bus_state !== SUSPEND) begin failures++; $display("FAIL susp_se0_119 got=%0d exp=%0d", bus_state, SUSPEND); end
    tick();
    checks++; if (bus_state !== BUS_RESET || usb_reset !== 1'b1) begin failures++; $display("FAIL susp_br got=%0d/%b exp=%0d/1", bus_state, usb_reset, BUS_RESET); end
    line_state = UTMI_LS_DK;
    tick();
  endtask

  task automatic test_turnaround;
    int bad;
    line_state = UTMI_LS_DK;
    tx_req = 1'b1; rx_active = 1'b1;
    tick(5);
    checks++; if (tx_gnt !== 1'b0) begin failures++; $display("FAIL ta_rx got=%b exp=0", tx_gnt); end
    rx_active = 1'b0;
    tick(8);
    checks++; if (tx_gnt !== 1'b0) begin failures++; $display("FAIL ta_8 got=%b exp=0", tx_gnt); end
    tick();
    checks++; if (tx_gnt !== 1'b1) begin failures++; $display("FAIL ta_9 got=%b exp=1", tx_gnt); end
    tx_active = 1'b1;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      rx_active = (i >= 10 && i < 14);
      tick();
      if (tx_gnt !== 1'b1) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL ta_hold low_cycles=%0d exp=0", bad); end
    tx_active = 1'b0; rx_active = 1'b0; tx_req = 1'b0;
    tick();
    checks++; if (tx_gnt !== 1'b0) begin failures++; $display("FAIL ta_drop got=%b exp=0", tx_gnt); end
    tick(12);
    tx_req = 1'b1;
    tick();
    checks++; if (tx_gnt !== 1'b1) begin failures++; $display("FAIL ta_lat1 got=%b exp=1", tx_gnt); end
    tx_req = 1'b0;
    tick(12);
    tx_req = 1'b1; rx_active = 1'b1;
    tick();
    checks++; if (tx_gnt !== 1'b0) begin failures++; $display("FAIL ta_coincide got=%b exp=0", tx_gnt); end
    tx_req = 1'b0; rx_active = 1'b0;
    tick(12);
  endtask

  task automatic test_grant_abort;
    line_state = UTMI_LS_DK;
    tx_req = 1'b1;
    tick();
    checks++; if (tx_gnt !== 1'b1) begin failures++; $display("FAIL ab_gnt got=%b exp=1", tx_gnt); end
    line_state = UTMI_LS_SE0;
    tick(119);
    checks++; if (tx_gnt !== 1'b1) begin failures++; $display("FAIL ab_119 got=%b exp=1", tx_gnt); end
    tick();
    checks++; if (tx_gnt !== 1'b0 || bus_state !== BUS_RESET) begin failures++; $display("FAIL ab_120 got=%b/%0d exp=0/%0d", tx_gnt, bus_state, BUS_RESET); end
    tx_req = 1'b0; line_state = UTMI_LS_DK;
    tick(2);
  endtask

  task automatic test_async_reset;
    line_state = UTMI_LS_DJ;
    tick(200);
    checks++; if (bus_state !== SUSPEND || suspend_m !== 1'b0) begin failures++; $display("FAIL ar_pre got=%0d/%b exp=%0d/0", bus_state, suspend_m, SUSPEND); end
    #2 rst = 1'b1;
    #1;
    checks++; if (bus_state !== ACTIVE || {suspend_m, usb_reset, tx_gnt, resume_det} !== 4'b1000) begin failures++; $display("FAIL ar_async got=%0d/%b exp=%0d/1000", bus_state, {suspend_m, usb_reset, tx_gnt, resume_det}, ACTIVE); end
    tick();
    rst = 1'b0;
    line_state = UTMI_LS_DK;
    tick(2);
  endtask

  initial begin
    test_reset();
    test_bus_reset();
    test_eop_immunity();
    test_suspend_resume();
    test_turnaround();
    test_grant_abort();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
